pps_delay_meter: RTL

//   Measures the propagation delay between a locally launched reference PPS and the same

---
 rtl/pps_delay_meter.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/pps_delay_meter.sv
// PPS loopback delay meter: times the gap between a launched reference PPS and its
// returned copy in clock cycles, reports it in ns, and keeps windowed avg/min/max.
module pps_delay_meter #(
    parameter int unsigned CLK_FREQ_HZ      = 100_000_000,
    parameter int unsigned MAX_DELAY_NS     = 1_000_000,
    parameter int unsigned AVG_LOG2         = 3,
    parameter int unsigned HALVE_ROUND_TRIP = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        meas_enable,
    input  logic        pps_ref,
    input  logic        pps_ret,
    output logic [31:0] meas_delay_ns,
    output logic        meas_valid,
    output logic [31:0] avg_delay_ns,
    output logic [31:0] min_delay_ns,
    output logic [31:0] max_delay_ns,
    output logic        avg_valid,
    output logic        timeout_err,
    output logic        overlap_err,
    output logic        busy
);

    localparam int unsigned CLK_PERIOD_NS = 1_000_000_000 / CLK_FREQ_HZ;
    localparam int unsigned TIMEOUT_CYC   = MAX_DELAY_NS / CLK_PERIOD_NS;
    localparam int unsigned WIN_SAMPLES   = 2 ** AVG_LOG2;
    localparam int unsigned SUM_W         = 32 + AVG_LOG2;
    localparam int unsigned WCNT_W        = AVG_LOG2 + 1;
    localparam logic [31:0] PERIOD_W      = 32'(CLK_PERIOD_NS);

    typedef enum logic [1:0] {StIdle, StArmed, StCount} state_e;

    state_e state_q, state_d;

    logic ref_d1, ref_d2, ret_d1, ret_d2;
    logic ref_edge, ret_edge;

    logic [31:0] cnt_q, cnt_d, cnt_inc;
    logic        timeout_hit;

    logic        sample_take, timeout_evt, overlap_evt;
    logic [31:0] sample_cycles, sample_prod, sample_ns;

    logic [SUM_W-1:0]  acc_q, acc_d;
    logic [31:0]       wmin_q, wmin_d, wmax_q, wmax_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic              win_done_q, win_done_d;
    logic [31:0]       avg_now;

    // Identical synchronisers on both inputs so their latency cancels in the difference
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_d1 <= 1'b0;
            ref_d2 <= 1'b0;
            ret_d1 <= 1'b0;
            ret_d2 <= 1'b0;
        end else begin
            ref_d1 <= pps_ref;
            ref_d2 <= ref_d1;
            ret_d1 <= pps_ret;
            ret_d2 <= ret_d1;
        end
    end

    assign ref_edge    = ref_d1 & ~ref_d2;
    assign ret_edge    = ret_d1 & ~ret_d2;
    assign cnt_inc     = cnt_q + 32'd1;
    assign timeout_hit = (cnt_inc == TIMEOUT_CYC);

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state; a return edge always wins over a coincident timeout
    always_comb begin
        state_d = state_q;
        if (!meas_enable) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle:  state_d = StArmed;
                StArmed: if (ref_edge && !ret_edge) state_d = StCount;
                StCount: begin
                    if (ret_edge) begin
                        state_d = ref_edge ? StCount : StArmed;
                    end else if (!ref_edge && timeout_hit) begin
                        state_d = StArmed;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // FSM outputs: measurement events and counter next value.
    // cnt_inc is the number of cycles elapsed since the ref edge was seen.
    always_comb begin
        sample_take   = 1'b0;
        sample_cycles = '0;
        timeout_evt   = 1'b0;
        overlap_evt   = 1'b0;
        cnt_d         = '0;
        if (meas_enable) begin
            case (state_q)
                StArmed: begin
                    if (ref_edge && ret_edge) sample_take = 1'b1;
                end
                StCount: begin
                    cnt_d = cnt_inc;
                    if (ret_edge) begin
                        sample_take   = 1'b1;
                        sample_cycles = cnt_inc;
                        if (ref_edge) cnt_d = '0;
                    end else if (ref_edge) begin
                        overlap_evt = 1'b1;
                        cnt_d       = '0;
                    end else if (timeout_hit) begin
                        timeout_evt = 1'b1;
                        cnt_d       = '0;
                    end
                end
                default: cnt_d = '0;
            endcase
        end
    end

    assign sample_prod = sample_cycles * PERIOD_W;
    assign sample_ns   = (HALVE_ROUND_TRIP != 0) ? (sample_prod >> 1) : sample_prod;

    // Window accumulation; wcnt==0 stands in for the all-ones min / zero max start values
    always_comb begin
        acc_d      = acc_q;
        wmin_d     = wmin_q;
        wmax_d     = wmax_q;
        wcnt_d     = wcnt_q;
        win_done_d = 1'b0;
        if (!meas_enable) begin
            acc_d  = '0;
            wmin_d = '0;
            wmax_d = '0;
            wcnt_d = '0;
        end else begin
            if (win_done_q) begin
                acc_d  = '0;
                wmin_d = '0;
                wmax_d = '0;
                wcnt_d = '0;
            end
            if (sample_take) begin
                acc_d      = acc_d + SUM_W'(sample_ns);
                wmin_d     = (wcnt_d == '0 || sample_ns < wmin_d) ? sample_ns : wmin_d;
                wmax_d     = (wcnt_d == '0 || sample_ns > wmax_d) ? sample_ns : wmax_d;
                wcnt_d     = wcnt_d + WCNT_W'(1);
                win_done_d = (32'(wcnt_d) == WIN_SAMPLES);
            end
        end
    end

    assign avg_now = 32'(acc_q >> AVG_LOG2);

    // Counter, window state and registered results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            acc_q         <= '0;
            wmin_q        <= '0;
            wmax_q        <= '0;
            wcnt_q        <= '0;
            win_done_q    <= 1'b0;
            meas_delay_ns <= '0;
            meas_valid    <= 1'b0;
            avg_delay_ns  <= '0;
            min_delay_ns  <= '0;
            max_delay_ns  <= '0;
            avg_valid     <= 1'b0;
            timeout_err   <= 1'b0;
            overlap_err   <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            wmin_q      <= wmin_d;
            wmax_q      <= wmax_d;
            wcnt_q      <= wcnt_d;
            win_done_q  <= win_done_d;
            meas_valid  <= sample_take;
            timeout_err <= timeout_evt;
            overlap_err <= overlap_evt;
            avg_valid   <= meas_enable & win_done_q;
            if (sample_take) meas_delay_ns <= sample_ns;
            if (meas_enable && win_done_q) begin
                avg_delay_ns <= avg_now;
                min_delay_ns <= wmin_q;
                max_delay_ns <= wmax_q;
            end
        end
    end

    assign busy = (state_q != StIdle);

endmodule
